// File: rtl/display_scheduler_if.sv
// display_scheduler_if: display bus shared by the PIN view, the message source and the scheduler
interface display_scheduler_if;
    logic        tick_in;
    logic [16:0] pin_in;
    logic        pin_mask;
    logic        msg_req;
    logic [15:0] msg_code;
    logic        msg_ack;
    logic [15:0] hex_bcd;
    logic        owner;
    logic        busy;
    modport master (
        output tick_in, pin_in, pin_mask, msg_req, msg_code,
        input  msg_ack, hex_bcd, owner, busy
    );
    modport slave (
        input  tick_in, pin_in, pin_mask, msg_req, msg_code,
        output msg_ack, hex_bcd, owner, busy
    );
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates the 4-digit BCD display between the PIN view and timed, blinking messages
module display_scheduler #(
    parameter int unsigned MSG_TICKS   = 2000,
    parameter int unsigned BLINK_TICKS = 250,
    parameter int unsigned CNT_W       = 16
) (
    input logic                clock,
    input logic                reset,
    display_scheduler_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PIN  = 2'd1;
    localparam logic [1:0] S_MSG  = 2'd2;
    localparam int unsigned MSG_LEN = (MSG_TICKS == 0) ? 1 : MSG_TICKS;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0] BLINK_LEN = CNT_W'(BLINK_TICKS);

    logic [2:0]       sync_q, sync_d;
    logic [1:0]       state_q, state_d;
    logic [15:0]      code_q, code_d;
    logic [15:0]      hex_q, hex_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [CNT_W-1:0] blink_nx;
    logic             phase_q, phase_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             tick_p, msg_end, accept, blink_wrap;
    logic [15:0]      pin_view;

    // Next state: tick edge detection, message acceptance (priority over PIN tracking), tick/blink counting
    always_comb begin
        sync_d      = {sync_q[1:0], bus.tick_in};
        tick_p      = sync_q[1] & ~sync_q[2];
        msg_end     = (state_q == S_MSG) && tick_p && (tick_cnt_q == LAST_TICK);
        accept      = bus.msg_req && ((state_q != S_MSG) || msg_end);
        blink_nx    = blink_cnt_q + CNT_W'(1);
        blink_wrap  = (BLINK_LEN != '0) && (blink_nx == BLINK_LEN);
        state_d     = state_q;
        code_d      = code_q;
        tick_cnt_d  = tick_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (accept) begin
            state_d     = S_MSG;
            code_d      = bus.msg_code;
            tick_cnt_d  = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (msg_end) begin
            state_d = bus.pin_in[16] ? S_PIN : S_IDLE;
        end else if (state_q == S_MSG) begin
            if (tick_p) begin
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
                if (BLINK_LEN != '0) begin
                    blink_cnt_d = blink_wrap ? '0 : blink_nx;
                    phase_d     = blink_wrap ? ~phase_q : phase_q;
                end
            end
        end else begin
            state_d = bus.pin_in[16] ? S_PIN : S_IDLE;
        end
        ack_d  = accept;
        busy_d = (state_q == S_MSG);
    end

    // Display contents for the current owner; masked PIN digits become dashes, blanks stay blank
    always_comb begin
        pin_view = bus.pin_in[15:0];
        for (int i = 0; i < 4; i++)
            if (bus.pin_mask && bus.pin_in[4*i +: 4] != 4'hF)
                pin_view[4*i +: 4] = 4'hB;
        hex_d = (state_q == S_MSG) ? (phase_q ? code_q : 16'hFFFF) :
                (state_q == S_PIN) ? pin_view : 16'hFFFF;
    end

    // State, counters and registered outputs; reset blanks the display and aborts any message
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= S_IDLE;
            code_q      <= 16'hFFFF;
            hex_q       <= 16'hFFFF;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            code_q      <= code_d;
            hex_q       <= hex_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.msg_ack = ack_q;
    assign bus.hex_bcd = hex_q;
    assign bus.owner   = busy_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed checks of PIN view, message timing, blinking, back-to-back and reset abort
module tb_display_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   acks_a = 0;
    int   acks_b = 0;
    int   base;

    display_scheduler_if ia ();
    display_scheduler_if ib ();

    display_scheduler #(.MSG_TICKS(4), .BLINK_TICKS(2), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .bus(ia.slave)
    );
    display_scheduler #(.MSG_TICKS(0), .BLINK_TICKS(0), .CNT_W(16)) dut_b (
        .clock(clock), .reset(reset), .bus(ib.slave)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ia.msg_ack === 1'b1) acks_a++;
        if (ib.msg_ack === 1'b1) acks_b++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // one tick_in pulse; returns one clock after the counting edge so hex_bcd reflects it
    task automatic do_tick_a();
        ia.tick_in = 1'b1;
        step(1);
        ia.tick_in = 1'b0;
        step(3);
    endtask

    task automatic start_msg_a(input logic [15:0] code);
        ia.msg_req  = 1'b1;
        ia.msg_code = code;
        step(1);
        ia.msg_req = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests++;
        if ({ia.hex_bcd, ia.owner, ia.busy, ia.msg_ack} !== {16'hFFFF, 3'b000}) begin
            failed++;
            $display("FAIL reset_a: got hex=%h own=%b busy=%b ack=%b expected FFFF 0 0 0", ia.hex_bcd, ia.owner, ia.busy, ia.msg_ack);
        end
        tests++;
        if ({ib.hex_bcd, ib.owner, ib.busy, ib.msg_ack} !== {16'hFFFF, 3'b000}) begin
            failed++;
            $display("FAIL reset_b: got hex=%h own=%b busy=%b ack=%b expected FFFF 0 0 0", ib.hex_bcd, ib.owner, ib.busy, ib.msg_ack);
        end
        step(2);
        reset = 1'b0;
        step(2);
        tests++;
        if (ia.hex_bcd !== 16'hFFFF) begin
            failed++;
            $display("FAIL idle_blank: got %h expected FFFF", ia.hex_bcd);
        end
    endtask

    task automatic test_pin_view();
        ia.pin_in = {1'b1, 16'h123F};
        step(2);
        tests++;
        if ({ia.hex_bcd, ia.owner} !== {16'h123F, 1'b0}) begin
            failed++;
            $display("FAIL pin_live: got hex=%h own=%b expected 123F 0", ia.hex_bcd, ia.owner);
        end
        ia.pin_mask = 1'b1;
        step(1);
        tests++;
        if (ia.hex_bcd !== 16'hBBBF) begin
            failed++;
            $display("FAIL pin_mask: got %h expected BBBF", ia.hex_bcd);
        end
        ia.pin_mask = 1'b0;
        ia.pin_in[16] = 1'b0;
        step(2);
        tests++;
        if (ia.hex_bcd !== 16'hFFFF) begin
            failed++;
            $display("FAIL pin_exit: got %h expected FFFF", ia.hex_bcd);
        end
        ia.pin_in[16] = 1'b1;
        step(2);
    endtask

    task automatic test_msg_blink();
        base = acks_a;
        ia.msg_req  = 1'b1;
        ia.msg_code = 16'h0E0E;
        step(1);
        tests++;
        if (ia.msg_ack !== 1'b1) begin
            failed++;
            $display("FAIL msg_ack: got %b expected 1", ia.msg_ack);
        end
        ia.msg_req = 1'b0;
        step(1);
        tests++;
        if ({ia.hex_bcd, ia.owner, ia.busy, ia.msg_ack} !== {16'h0E0E, 3'b110}) begin
            failed++;
            $display("FAIL msg_show: got hex=%h own=%b busy=%b ack=%b expected 0E0E 1 1 0", ia.hex_bcd, ia.owner, ia.busy, ia.msg_ack);
        end
        do_tick_a();
        tests++;
        if (ia.hex_bcd !== 16'h0E0E) begin
            failed++;
            $display("FAIL msg_tick1: got %h expected 0E0E", ia.hex_bcd);
        end
        do_tick_a();
        tests++;
        if (ia.hex_bcd !== 16'hFFFF) begin
            failed++;
            $display("FAIL msg_tick2: got %h expected FFFF", ia.hex_bcd);
        end
        do_tick_a();
        tests++;
        if ({ia.hex_bcd, ia.busy} !== {16'hFFFF, 1'b1}) begin
            failed++;
            $display("FAIL msg_tick3: got hex=%h busy=%b expected FFFF 1", ia.hex_bcd, ia.busy);
        end
        do_tick_a();
        tests++;
        if ({ia.hex_bcd, ia.owner, ia.busy} !== {16'h123F, 2'b00}) begin
            failed++;
            $display("FAIL msg_end: got hex=%h own=%b busy=%b expected 123F 0 0", ia.hex_bcd, ia.owner, ia.busy);
        end
        tests++;
        if (acks_a - base !== 1) begin
            failed++;
            $display("FAIL msg_ack_count: got %0d expected 1", acks_a - base);
        end
    endtask

    task automatic test_back_to_back();
        start_msg_a(16'h0E0E);
        base = acks_a;
        do_tick_a();
        ia.msg_req  = 1'b1;
        ia.msg_code = 16'h5555;
        do_tick_a();
        do_tick_a();
        tests++;
        if (acks_a - base !== 0) begin
            failed++;
            $display("FAIL b2b_wait: got %0d acks expected 0", acks_a - base);
        end
        ia.tick_in = 1'b1;
        step(1);
        ia.tick_in = 1'b0;
        step(2);
        tests++;
        if ({ia.msg_ack, ia.busy, ia.hex_bcd} !== {2'b11, 16'hFFFF}) begin
            failed++;
            $display("FAIL b2b_ack: got ack=%b busy=%b hex=%h expected 1 1 FFFF", ia.msg_ack, ia.busy, ia.hex_bcd);
        end
        ia.msg_req  = 1'b0;
        ia.msg_code = 16'h9999;
        step(1);
        tests++;
        if ({ia.hex_bcd, ia.busy} !== {16'h5555, 1'b1}) begin
            failed++;
            $display("FAIL b2b_show: got hex=%h busy=%b expected 5555 1", ia.hex_bcd, ia.busy);
        end
        repeat (4) do_tick_a();
        tests++;
        if ({ia.hex_bcd, ia.busy} !== {16'h123F, 1'b0}) begin
            failed++;
            $display("FAIL b2b_end: got hex=%h busy=%b expected 123F 0", ia.hex_bcd, ia.busy);
        end
    endtask

    task automatic test_dropped_req();
        start_msg_a(16'h0E0E);
        base = acks_a;
        ia.msg_req  = 1'b1;
        ia.msg_code = 16'h7777;
        step(2);
        ia.msg_req = 1'b0;
        repeat (4) do_tick_a();
        step(2);
        tests++;
        if ({ia.hex_bcd, ia.busy} !== {16'h123F, 1'b0}) begin
            failed++;
            $display("FAIL drop_state: got hex=%h busy=%b expected 123F 0", ia.hex_bcd, ia.busy);
        end
        tests++;
        if (acks_a - base !== 0) begin
            failed++;
            $display("FAIL drop_ack: got %0d acks expected 0", acks_a - base);
        end
    endtask

    task automatic test_tick_at_accept();
        ia.tick_in = 1'b1;
        step(1);
        ia.tick_in = 1'b0;
        step(1);
        ia.msg_req  = 1'b1;
        ia.msg_code = 16'h0E0E;
        step(1);
        ia.msg_req = 1'b0;
        tests++;
        if (ia.msg_ack !== 1'b1) begin
            failed++;
            $display("FAIL tacc_ack: got %b expected 1", ia.msg_ack);
        end
        repeat (3) do_tick_a();
        tests++;
        if ({ia.hex_bcd, ia.busy} !== {16'hFFFF, 1'b1}) begin
            failed++;
            $display("FAIL tacc_3: got hex=%h busy=%b expected FFFF 1", ia.hex_bcd, ia.busy);
        end
        do_tick_a();
        tests++;
        if ({ia.hex_bcd, ia.busy} !== {16'h123F, 1'b0}) begin
            failed++;
            $display("FAIL tacc_4: got hex=%h busy=%b expected 123F 0", ia.hex_bcd, ia.busy);
        end
    endtask

    task automatic test_tick_held();
        start_msg_a(16'hAAAA);
        ia.tick_in = 1'b1;
        step(20);
        ia.tick_in = 1'b0;
        step(3);
        do_tick_a();
        do_tick_a();
        tests++;
        if ({ia.hex_bcd, ia.busy} !== {16'hFFFF, 1'b1}) begin
            failed++;
            $display("FAIL held_3: got hex=%h busy=%b expected FFFF 1", ia.hex_bcd, ia.busy);
        end
        do_tick_a();
        tests++;
        if ({ia.hex_bcd, ia.busy} !== {16'h123F, 1'b0}) begin
            failed++;
            $display("FAIL held_4: got hex=%h busy=%b expected 123F 0", ia.hex_bcd, ia.busy);
        end
    endtask

    task automatic test_reset_mid_msg();
        start_msg_a(16'h0E0E);
        do_tick_a();
        do_tick_a();
        reset = 1'b1;
        #1;
        tests++;
        if ({ia.hex_bcd, ia.busy, ia.owner, ia.msg_ack} !== {16'hFFFF, 3'b000}) begin
            failed++;
            $display("FAIL rst_mid: got hex=%h busy=%b own=%b ack=%b expected FFFF 0 0 0", ia.hex_bcd, ia.busy, ia.owner, ia.msg_ack);
        end
        ia.pin_in[16] = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        tests++;
        if ({ia.hex_bcd, ia.busy} !== {16'hFFFF, 1'b0}) begin
            failed++;
            $display("FAIL rst_idle: got hex=%h busy=%b expected FFFF 0", ia.hex_bcd, ia.busy);
        end
        ia.pin_in[16] = 1'b1;
        step(2);
        tests++;
        if (ia.hex_bcd !== 16'h123F) begin
            failed++;
            $display("FAIL rst_to_pin: got %h expected 123F", ia.hex_bcd);
        end
    endtask

    task automatic test_zero_params();
        base = acks_b;
        ib.msg_req  = 1'b1;
        ib.msg_code = 16'h1234;
        step(1);
        ib.msg_req = 1'b0;
        step(1);
        tests++;
        if ({ib.hex_bcd, ib.busy} !== {16'h1234, 1'b1}) begin
            failed++;
            $display("FAIL zero_show: got hex=%h busy=%b expected 1234 1", ib.hex_bcd, ib.busy);
        end
        ib.tick_in = 1'b1;
        step(1);
        ib.tick_in = 1'b0;
        step(2);
        tests++;
        if ({ib.hex_bcd, ib.busy} !== {16'h1234, 1'b1}) begin
            failed++;
            $display("FAIL zero_steady: got hex=%h busy=%b expected 1234 1", ib.hex_bcd, ib.busy);
        end
        step(1);
        tests++;
        if ({ib.hex_bcd, ib.busy, ib.owner} !== {16'hFFFF, 2'b00}) begin
            failed++;
            $display("FAIL zero_end: got hex=%h busy=%b own=%b expected FFFF 0 0", ib.hex_bcd, ib.busy, ib.owner);
        end
        step(1);
        tests++;
        if (acks_b - base !== 1) begin
            failed++;
            $display("FAIL zero_acks: got %0d expected 1", acks_b - base);
        end
    endtask

    initial begin
        ia.tick_in = 1'b0; ia.pin_in = '0; ia.pin_mask = 1'b0; ia.msg_req = 1'b0; ia.msg_code = '0;
        ib.tick_in = 1'b0; ib.pin_in = '0; ib.pin_mask = 1'b0; ib.msg_req = 1'b0; ib.msg_code = '0;
        #2;
        test_reset();
        test_pin_view();
        test_msg_blink();
        test_back_to_back();
        test_dropped_req();
        test_tick_at_accept();
        test_tick_held();
        test_reset_mid_msg();
        test_zero_params();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
